pipe_stall_scheduler: RTL
=========================

PIPE_STALL_SCHEDULER -- requirements
Module: pipe_stall_scheduler

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max MEM_WAIT cycles before abort, range 2..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_cycles counter.
REQ-003 SHALL have port clk  in  1: sole clock, rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port ld_use_stall  in  1: load-use hazard request from hazard detection unit.
REQ-006 SHALL have port br_redirect  in  1: taken branch/jal/jalr resolved in ID.
REQ-007 SHALL have port dmem_req  in  1: MEM-stage load/store active.
REQ-008 SHALL have port dmem_ready  in  1: data memory completes access this cycle.
REQ-009 SHALL have port md_start  in  1: EX-stage mul/div issue.
REQ-010 SHALL have port md_done  in  1: mul/div result valid this cycle.
REQ-011 SHALL have port cnt_clr  in  1: synchronous clear of stall_cycles.
REQ-012 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each: stage register load enables.
REQ-013 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each: insert bubble (control bits zero) into that register.
REQ-014 SHALL have port state  out  2: 0 RUN, 1 MEM_WAIT, 2 MD_WAIT, 3 unused.
REQ-015 SHALL have port mem_timeout  out  1: sticky, set on MEM_WAIT abort.
REQ-016 SHALL have port stall_cycles  out  CNT_W: count of cycles with pc_en=0.

Function
REQ-017 Enables/flushes SHALL be combinational from state and current inputs; state, wait counter, redirect_pending, mem_timeout, stall_cycles SHALL be registered.
REQ-018 Default (no event) SHALL be: all enables 1, all flushes 0.
REQ-019 Priority in RUN SHALL be: memory miss > mul/div > load-use > redirect.
REQ-020 RUN, dmem_req=1 and dmem_ready=0: all enables 0, mem_wb_flush=1; next state MEM_WAIT; wait counter loads 1.
REQ-021 MEM_WAIT, dmem_ready=0: same freeze as REQ-020; wait counter increments.
REQ-022 MEM_WAIT, dmem_ready=1: default outputs (release); next state RUN.
REQ-023 MEM_WAIT, dmem_ready=0 and wait counter = MEM_TIMEOUT-1: release as REQ-022 but mem_wb_flush=1, set mem_timeout, next state RUN.
REQ-024 RUN, md_start=1 and md_done=0 (no memory miss): pc_en, if_id_en, id_ex_en=0, ex_mem_flush=1; next state MD_WAIT.
REQ-025 MD_WAIT: freeze as REQ-024 until md_done=1; on md_done cycle default outputs, next state RUN; no timeout.
REQ-026 md_start and md_done both 1 in RUN: single-cycle op, no stall, stay RUN.
REQ-027 RUN, ld_use_stall=1 only: pc_en=0, if_id_en=0, id_ex_flush=1; stay RUN; one bubble per asserted cycle.
REQ-028 RUN, br_redirect=1 and ld_use_stall=0: if_id_flush=1, pc_en=1.
REQ-029 br_redirect with ld_use_stall in same cycle SHALL be ignored (operand not yet valid).
REQ-030 br_redirect=1 during MEM_WAIT or MD_WAIT SHALL set redirect_pending; no flush while frozen.
REQ-031 Release cycle (REQ-022/023/025) SHALL assert if_id_flush if br_redirect or redirect_pending; redirect_pending clears that cycle.
REQ-032 dmem_req=1 in MD_WAIT SHALL be ignored (MEM holds bubble).
REQ-033 stall_cycles SHALL increment when pc_en=0, saturate at all-ones; cnt_clr wins over increment.
REQ-034 mem_timeout SHALL clear only on reset.

Reset
REQ-035 rst=1 SHALL asynchronously force state=RUN, wait counter=0, redirect_pending=0, mem_timeout=0, stall_cycles=0.
REQ-036 During reset outputs SHALL equal default (REQ-018) with inputs low.
REQ-037 Reset in MEM_WAIT/MD_WAIT SHALL abandon the wait with no pending flush after release.

Verification
REQ-038 ld_use_stall=1 one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only; stall_cycles=1.
REQ-039 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> state=1 for 3 cycles, all enables 0, mem_wb_flush=1; 4th cycle enables 1, state=0.
REQ-040 md_start=1, md_done after 5 cycles, br_redirect=1 in cycle 2 -> pc_en=0 for 5 cycles, ex_mem_flush=1; if_id_flush=1 on md_done cycle only.
REQ-041 MEM_TIMEOUT=4, dmem_ready held 0 -> abort on 4th cycle, mem_timeout=1 sticky, state=0.
REQ-042 ld_use_stall=1 with br_redirect=1 -> if_id_flush=0, id_ex_flush=1.
REQ-043 rst asserted mid MD_WAIT -> immediate state=0, stall_cycles=0, default outputs.

Source files
------------

// File: rtl/pipe_stall_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stall_scheduler
//  Brief    : Stall/flush scheduler for a 5-stage pipeline (hazards, memory
//             and mul/div waits, branch redirect).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_scheduler #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use_stall,
    input  logic             br_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             w_set_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_wait       <= 8'd0;
            r_pend       <= 1'b0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_pend  <= w_pend_nxt;
            if (w_set_timeout)
                mem_timeout <= 1'b1;
            if (cnt_clr)
                stall_cycles <= '0;
            else if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_pend_nxt    = r_pend;
        w_set_timeout = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
                    mem_wb_flush = 1'b1;
                    w_state_nxt  = ST_MEM_WAIT;
                    w_wait_nxt   = 8'd1;
                    // A redirect resolved while ID freezes is replayed on release
                    w_pend_nxt   = br_redirect && !ld_use_stall;
                end else if (md_start && !md_done) begin
                    {pc_en, if_id_en, id_ex_en} = 3'b0;
                    ex_mem_flush = 1'b1;
                    w_state_nxt  = ST_MD_WAIT;
                    w_pend_nxt   = br_redirect && !ld_use_stall;
                end else if (ld_use_stall) begin
                    // Redirect is dropped: its operand is not yet valid
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (br_redirect) begin
                    if_id_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready || (r_wait == c_WAIT_LAST)) begin
                    if_id_flush   = br_redirect || r_pend;
                    mem_wb_flush  = !dmem_ready;
                    w_set_timeout = !dmem_ready;
                    w_pend_nxt    = 1'b0;
                    w_wait_nxt    = 8'd0;
                    w_state_nxt   = ST_RUN;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
                    mem_wb_flush = 1'b1;
                    w_wait_nxt   = r_wait + 8'd1;
                    if (br_redirect)
                        w_pend_nxt = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    if_id_flush = br_redirect || r_pend;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_RUN;
                end else begin
                    {pc_en, if_id_en, id_ex_en} = 3'b0;
                    ex_mem_flush = 1'b1;
                    if (br_redirect)
                        w_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire
